// File: rtl/fp_add_scheduler_pkg.sv
// fp_add_sched_pkg: shared types and constants for the FP32 adder scheduler.
// FP32 field widths, the default requester count and the scheduler state encoding.
package fp_add_sched_pkg;

  localparam int EXP_W       = 8;
  localparam int MAN_W       = 23;
  localparam int FP_WIDTH    = 1 + EXP_W + MAN_W;
  localparam int DEF_N       = 4;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/fp_add_scheduler_if.sv
// fp_add_scheduler_if: requester-side bus plus the shared-adder handshake.
// The slave modport is the scheduler; the master modport is the surrounding
// environment (compute units and the adder itself).
interface fp_add_scheduler_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32
);

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] op_a;
  logic [N*WIDTH-1:0] op_b;
  logic [N-1:0]       ack;
  logic [N-1:0]       resp_valid;
  logic [WIDTH-1:0]   resp_data;
  logic               resp_err;
  logic               busy;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_strt;
  logic               add_busy;
  logic               add_valid;
  logic [WIDTH-1:0]   add_out;

  modport slave (
    input  req, op_a, op_b, add_busy, add_valid, add_out,
    output ack, resp_valid, resp_data, resp_err, busy, add_a, add_b, add_strt
  );

  modport master (
    output req, op_a, op_b, add_busy, add_valid, add_out,
    input  ack, resp_valid, resp_data, resp_err, busy, add_a, add_b, add_strt
  );

endinterface

// File: rtl/fp_add_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker. Searches upward from the
// pointer position and wraps, so the requester at the pointer has top priority.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic [ID_W-1:0] o_id,
  output logic            o_any
);

  int w_idx;

  // Pick the first active request at or after the pointer, wrapping around.
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    o_any   = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_id           = ID_W'(w_idx);
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: shares one pipelined FP32 adder among N requesters.
// Round-robin grant, one operation in flight, sum routed back to its issuer.
// Optional watchdog: define FP_ADD_SCHED_TIMEOUT_EN to abort a WAIT that
// lasts TIMEOUT cycles, answering with resp_err=1 and resp_data=0.
module fp_add_scheduler
  import fp_add_sched_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int WIDTH   = FP_WIDTH,
  parameter int ID_W    = $clog2(N),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               rst,
  fp_add_scheduler_if.slave bus
);

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  sched_state_t     r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic             r_add_strt;
  logic [N-1:0]     r_ack;
  logic [N-1:0]     r_resp_valid;
  logic [WIDTH-1:0] r_resp_data;
  logic             r_busy;

  logic [N-1:0]     w_grant;
  logic [ID_W-1:0]  w_gnt_id;
  logic             w_any;
  logic [ID_W-1:0]  w_ptr_nxt;

`ifdef FP_ADD_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_resp_err;
`endif

  rr_arbiter #(.N(N), .ID_W(ID_W)) u_arb (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_id    (w_gnt_id),
    .o_any   (w_any)
  );

  // Pointer after serving r_id: the next requester, wrapping at N.
  always_comb begin
    if (r_id == ID_W'(N - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = r_id + ID_W'(1);
    end
  end

  // Scheduler FSM with registered handshake, operand and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_id         <= '0;
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_add_strt   <= 1'b0;
      r_ack        <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_busy       <= 1'b0;
`ifdef FP_ADD_SCHED_TIMEOUT_EN
      r_cnt        <= '0;
      r_resp_err   <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; each state raises only what it owns.
      r_ack        <= '0;
      r_resp_valid <= '0;
      r_add_strt   <= 1'b0;
`ifdef FP_ADD_SCHED_TIMEOUT_EN
      r_resp_err   <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_ack   <= w_grant;
            r_id    <= w_gnt_id;
            r_add_a <= bus.op_a[int'(w_gnt_id)*WIDTH +: WIDTH];
            r_add_b <= bus.op_b[int'(w_gnt_id)*WIDTH +: WIDTH];
            r_busy  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          // Hold off the start pulse while the adder reports busy.
          if (!bus.add_busy) begin
            r_add_strt <= 1'b1;
            r_state    <= WAIT;
`ifdef FP_ADD_SCHED_TIMEOUT_EN
            r_cnt      <= '0;
`endif
          end
        end
        WAIT: begin
          if (bus.add_valid) begin
            r_resp_data  <= bus.add_out;
            r_resp_valid <= ONE_HOT0 << r_id;
            r_state      <= RESP;
`ifdef FP_ADD_SCHED_TIMEOUT_EN
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_resp_data  <= '0;
            r_resp_err   <= 1'b1;
            r_resp_valid <= ONE_HOT0 << r_id;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
`endif
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_ptr   <= w_ptr_nxt;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack        = r_ack;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.busy       = r_busy;
  assign bus.add_a      = r_add_a;
  assign bus.add_b      = r_add_b;
  assign bus.add_strt   = r_add_strt;
`ifdef FP_ADD_SCHED_TIMEOUT_EN
  assign bus.resp_err   = r_resp_err;
`else
  assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fp_add_scheduler.sv
// tb_fp_add_scheduler: randomized and directed bench for fp_add_scheduler with
// a 3-cycle adder model and a transaction-level reference model.
module tb_fp_add_scheduler;
  import fp_add_sched_pkg::*;

  localparam int N       = 4;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fp_add_scheduler_if #(.N(N), .WIDTH(WIDTH)) bus ();

  fp_add_scheduler #(.N(N), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- FP32 arithmetic via real numbers ----------------
  function automatic real fp2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2fp(fp2r(a) + fp2r(b));
  endfunction

  // Operands whose sums are exact in FP32: 8 significant bits, exponents close.
  function automatic logic [31:0] gen_op();
    logic [31:0] v;
    v = {1'($urandom_range(0, 1)), 8'($urandom_range(124, 131)), 7'($urandom_range(0, 127)), 16'd0};
    return v;
  endfunction

  // ---------------- adder model: result 3 cycles after start ----------------
  logic        busy_force = 1'b0;
  logic        mute       = 1'b0;
  logic        stray_req  = 1'b0;
  logic [1:0]  pv;
  logic [31:0] s0, s1;

  assign bus.add_busy = busy_force;

  // Two internal stages then a registered result pulse; strays only when idle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv            <= 2'd0;
      s0            <= 32'd0;
      s1            <= 32'd0;
      bus.add_valid <= 1'b0;
      bus.add_out   <= 32'd0;
    end else begin
      pv <= {pv[0], bus.add_strt & ~mute};
      s0 <= fp_add(bus.add_a, bus.add_b);
      s1 <= s0;
      if (pv[1]) begin
        bus.add_valid <= 1'b1;
        bus.add_out   <= s1;
      end else if (stray_req) begin
        bus.add_valid <= 1'b1;
        bus.add_out   <= $urandom;
      end else begin
        bus.add_valid <= 1'b0;
      end
    end
  end

  // ---------------- reference model and per-cycle compare ----------------
  int          ph;       // 0 free, 1 granted, 2 adding, 3 answering
  int          m_ptr, m_id, m_cnt;
  logic [N-1:0] e_ack, e_rv;
  logic        e_busy, e_strt, e_err;
  logic [31:0] e_a, e_b, e_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; m_ptr = 0; m_id = 0; m_cnt = 0;
      e_ack = '0; e_rv = '0; e_busy = 1'b0; e_strt = 1'b0; e_err = 1'b0;
      e_a = 32'd0; e_b = 32'd0; e_data = 32'd0;
    end else begin
      logic [N-1:0] rq;
      logic         ab, av;
      logic [31:0]  ao;
      rq = bus.req; ab = bus.add_busy; av = bus.add_valid; ao = bus.add_out;
      e_ack = '0; e_rv = '0; e_strt = 1'b0; e_err = 1'b0;
      case (ph)
        0: if (rq != '0) begin
             for (int k = 0; k < N; k++) begin
               int idx;
               idx = (m_ptr + k) % N;
               if (e_ack == '0 && rq[idx]) begin
                 e_ack[idx] = 1'b1;
                 m_id = idx;
               end
             end
             e_a = bus.op_a[m_id*WIDTH +: WIDTH];
             e_b = bus.op_b[m_id*WIDTH +: WIDTH];
             e_busy = 1'b1;
             ph = 1;
           end
        1: if (!ab) begin e_strt = 1'b1; m_cnt = 0; ph = 2; end
        2: if (av) begin
             e_data = ao; e_rv[m_id] = 1'b1; ph = 3;
`ifdef FP_ADD_SCHED_TIMEOUT_EN
           end else if (m_cnt == TIMEOUT - 1) begin
             e_data = 32'd0; e_err = 1'b1; e_rv[m_id] = 1'b1; ph = 3;
           end else begin
             m_cnt++;
`endif
           end
        default: begin e_busy = 1'b0; m_ptr = (m_id + 1) % N; ph = 0; end
      endcase
      #1;
      chk("ack", bus.ack, e_ack);
      chk("resp_valid", bus.resp_valid, e_rv);
      chk("resp_err", bus.resp_err, e_err);
      chk("resp_data", bus.resp_data, e_data);
      chk("busy", bus.busy, e_busy);
      chk("add_strt", bus.add_strt, e_strt);
      chk("add_a", bus.add_a, e_a);
      chk("add_b", bus.add_b, e_b);
      if (e_rv != '0 && !e_err) chk("sum", bus.resp_data, fp_add(e_a, e_b));
    end
  end

  // Ack order log for the arbitration checks.
  int ack_log[$];
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) if (bus.ack[i]) ack_log.push_back(i);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.op_a[i*WIDTH +: WIDTH] = a;
    bus.op_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic raise(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        set_ops(i, gen_op(), gen_op());
        bus.req[i] = 1'b1;
      end
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      bus.req = bus.req & ~bus.ack;
      if (bus.req == '0 && !bus.busy) return;
    end
    bound_expired("drain");
  endtask

  task automatic wait_resp(input int id, output int cyc, output logic [31:0] data, output logic err);
    cyc = 0; data = 32'd0; err = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      bus.req = bus.req & ~bus.ack;
      if (bus.resp_valid != '0) begin
        cyc = c; data = bus.resp_data; err = bus.resp_err;
        chk("resp_tag", bus.resp_valid, 4'b0001 << id);
        return;
      end
    end
    bound_expired("wait_resp");
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, bus.ack, '0);
    chk({tag, "_resp_valid"}, bus.resp_valid, '0);
    chk({tag, "_resp_data"}, bus.resp_data, 32'd0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_add_a"}, bus.add_a, 32'd0);
    chk({tag, "_add_strt"}, bus.add_strt, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int          cyc, strt0;
    logic [31:0] data;
    logic        err;
    bus.req  = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    #2 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Model pins.
    chk("pin_1p1", fp_add(32'h3F800000, 32'h3F800000), 32'h40000000);
    chk("pin_2p5m1", fp_add(32'h40200000, 32'hBF800000), 32'h3FC00000);

    // Single request: 1.0 + 1.0, nominal latency.
    @(negedge clk);
    set_ops(0, 32'h3F800000, 32'h3F800000);
    bus.req[0] = 1'b1;
    strt0 = 0;
    fork
      begin
        for (int c = 0; c < 8; c++) begin @(posedge clk); #1; strt0 += int'(bus.add_strt); end
      end
    join_none
    wait_resp(0, cyc, data, err);
    chk("single_latency", cyc, 6);
    chk("single_data", data, 32'h40000000);
    chk("single_err", err, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("single_strt_count", strt0, 1);

    // Mixed sign on requester 2.
    @(negedge clk);
    set_ops(2, 32'h40200000, 32'hBF800000);
    bus.req[2] = 1'b1;
    wait_resp(2, cyc, data, err);
    chk("mixed_data", data, 32'h3FC00000);
    drain();

    // Fairness from reset: two full rounds, both in index order.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    ack_log.delete();
    raise(4'b1111); drain();
    raise(4'b1111); drain();
    chk("fair_len", ack_log.size(), 8);
    for (int i = 0; i < 8 && i < ack_log.size(); i++) chk("fair_order", ack_log[i], i % 4);

    // Pointer wrap: after serving 3, requester 0 beats 3.
    ack_log.delete();
    @(negedge clk); raise(4'b1000); drain();
    @(negedge clk); raise(4'b1001); drain();
    chk("wrap_len", ack_log.size(), 3);
    if (ack_log.size() == 3) begin
      chk("wrap_first", ack_log[0], 3);
      chk("wrap_second", ack_log[1], 0);
      chk("wrap_third", ack_log[2], 3);
    end

    // Reset one cycle after the start pulse.
    @(negedge clk); raise(4'b0010);
    cyc = 0;
    for (int c = 0; c < 20 && cyc == 0; c++) begin
      @(posedge clk); #1;
      bus.req = bus.req & ~bus.ack;
      if (bus.add_strt) cyc = c + 1;
    end
    if (cyc == 0) bound_expired("wait_strt");
    @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    chk_all_zero("midreset");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    set_ops(1, 32'h3F800000, 32'h40000000);
    bus.req[1] = 1'b1;
    wait_resp(1, cyc, data, err);
    chk("after_reset_data", data, 32'h40400000);
    chk("after_reset_latency", cyc, 6);
    drain();

    // Randomized traffic with adder stalls, stray results and early withdrawals.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus.req = bus.req & ~bus.ack;
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
          set_ops(i, gen_op(), gen_op());
          bus.req[i] = 1'b1;
        end else if (bus.req[i] && $urandom_range(0, 31) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
      busy_force = ($urandom_range(0, 3) == 0);
      stray_req  = !bus.busy && ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    busy_force = 1'b0;
    stray_req  = 1'b0;
    drain();

`ifdef FP_ADD_SCHED_TIMEOUT_EN
    // Watchdog abort, then a late stray result that must be ignored.
    mute = 1'b1;
    @(negedge clk); raise(4'b0010);
    wait_resp(1, cyc, data, err);
    chk("timeout_err", err, 1'b1);
    chk("timeout_data", data, 32'd0);
    chk("timeout_latency", cyc, 18);
    mute = 1'b0;
    @(negedge clk); @(negedge clk);
    stray_req = 1'b1;
    @(negedge clk); stray_req = 1'b0;
    repeat (4) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_add_scheduler.md
Name: fp_add_scheduler

Overview:
- Shares one pipelined FP32 adder instance among N requesters.
- Uses a round-robin arbiter. Sequences the adder's strt/busy/valid handshake and returns each sum to the requester that issued it.
- Sits between the layer-level compute units and the single adder; owns the adder's input operands and start pulse.
- One operation is in flight at a time.

Parameters:
- N, 4, number of requesters (2..8).
- WIDTH, 32, operand/result width (exponent 8 + mantissa 23 + sign).
- ID_W, $clog2(N), requester index width.
- TIMEOUT, 16, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk, in, 1, clock; reset rst, asynchronous, active-high.
- rst, in, 1, asynchronous active-high reset.
- req, in, N, per-requester request level; held until the matching ack.
- op_a, in, N*WIDTH, packed operand A; slice i belongs to requester i.
- op_b, in, N*WIDTH, packed operand B.
- ack, out, N, one-hot, one-cycle pulse: request accepted, operands captured.
- resp_valid, out, N, one-hot, one-cycle pulse: result for requester i is on resp_data.
- resp_data, out, WIDTH, registered sum.
- resp_err, out, 1, qualifies resp_valid; 1 = watchdog abort.
- busy, out, 1, high from grant until response is issued.
- add_a, out, WIDTH, adder operand 1.
- add_b, out, WIDTH, adder operand 2.
- add_strt, out, 1, adder start.
- add_busy, in, 1, adder busy.
- add_valid, in, 1, adder result pulse.
- add_out, in, WIDTH, adder result.

Behaviour:
- Reset: every output is 0; state=IDLE; rr pointer=0; captured operands=0; grant id=0.
- States and transitions:
  - IDLE: if any req, pick the winner via round-robin starting at pointer. Capture op_a/op_b slices into add_a/add_b. Pulse ack[winner] and store the winner id. Set busy=1, go to ISSUE.
  - ISSUE: add_strt=1 for exactly one cycle, go to WAIT. If add_busy is already 1 (adder not idle), stay in ISSUE with add_strt=0 until add_busy=0.
  - WAIT: add_strt=0. On add_valid=1, register add_out into resp_data and go to RESP.
  - RESP: resp_valid[id]=1 for one cycle with resp_err=0. busy=0 at the next edge. Pointer = (id+1) mod N; IDLE.
- Operand stability: add_a/add_b hold their captured values from IDLE exit until RESP exit. The adder may sample them any time up to its first internal stage.
- Latency: req seen in IDLE at cycle 0.
  - ack in cycle 0 (combinational from registered state, registered output at edge 1).
  - add_strt in cycle 1; adder valid arrives 3 cycles after strt.
  - resp_valid 1 cycle after add_valid.
  - Nominal req-to-resp is 6 cycles; back-to-back service of the next requester starts the cycle after RESP.
- Arbitration:
  - Only the requester at the pointer position or above wins first, then wrap-around.
  - A requester deasserting req before ack is simply skipped; no error.
  - Simultaneous req from all N is served in order pointer, pointer+1, …
- add_valid outside WAIT is ignored. resp_data keeps its last value between responses.
- Mid-operation rst (the adder shares the same rst) returns to IDLE immediately. No resp_valid is issued for the aborted op, and the pointer resets to 0.

Optional Feature:
- Macro FP_ADD_SCHED_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT and clears on state entry.
  - If it reaches TIMEOUT without add_valid, go to RESP with resp_data=0 and resp_err=1, then advance the pointer normally.
  - A late add_valid arriving after the abort is ignored.
- Not defined: no counter; WAIT waits indefinitely; resp_err tied 0.

Decomposition:
- Package fp_add_sched_pkg: state enum (IDLE, ISSUE, WAIT, RESP), FP_WIDTH=32, EXP_W=8, MAN_W=23, default N constant.
- One sub-module, rr_arbiter: combinational round-robin picker.
  - Inputs: req[N], pointer.
  - Outputs: one-hot grant, grant id, any_req.
- The FSM, operand registers and watchdog stay in the top.

Test Plan:
- Single request: req[0], a=0x3F800000 (1.0), b=0x3F800000 → ack[0] pulse; one add_strt; resp_valid[0] with resp_data=0x40000000; nominal latency 6 cycles.
- Mixed sign: req[2], a=0x40200000 (2.5), b=0xBF800000 (-1.0) → resp_valid[2], resp_data=0x3FC00000 (1.5).
- Fairness: req[3:0] all held high with distinct operands from reset → acks in order 0,1,2,3; responses tagged to the matching index; a second round starts at 0 again.
- Pointer wrap: serve req[3], then raise req[0] and req[3] together → 0 is granted before 3.
- Reset in WAIT: assert rst 1 cycle after add_strt → all outputs 0, no resp_valid. A new req[1] afterwards completes normally.
- Timeout (macro defined, adder model never asserts add_valid): req[1] → after TIMEOUT=16 cycles in WAIT, resp_valid[1] with resp_err=1 and resp_data=0. A later stray add_valid is ignored.
